// File: rtl/matmul_controller.sv
// matmul_controller: sequences a single-port, zero-wait data memory to compute
// C = A x B for square N x N row-major matrices.
// Per C element: N pairs of (READ_A, READ_B) accumulate one product each, then
// one WRITE stores the sum, giving 2N+1 cycles per element.
// All memory-port outputs are a Moore decode of the state and index counters.
module matmul_controller #(
  parameter int N      = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int A_BASE = 0,
  parameter int B_BASE = 9,
  parameter int C_BASE = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  // Counters are one bit wider than needed to hold N-1.
  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       i_q, i_d;
  logic [CW-1:0]       j_q, j_d;
  logic [CW-1:0]       k_q, k_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   acc_q, acc_d;

  // Full-width product, truncated to DATA_W, then added modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] mac_wrap(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return acc + prod[DATA_W-1:0];
  endfunction

  // Row-major element address; all terms are evaluated at ADDR_W and wrap.
  function automatic logic [ADDR_W-1:0] elem_addr(
    input int            base,
    input logic [CW-1:0] row,
    input logic [CW-1:0] col
  );
    return ADDR_W'(base) + ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

  // State, index counters and datapath registers; reset returns to IDLE cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state and counter/accumulator update logic.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_READ_A;
        end
      end
      S_READ_A: begin
        a_d     = mem_read_data;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        acc_d = mac_wrap(acc_q, a_q, mem_read_data);
        if (k_q == LAST) begin
          state_d = S_WRITE;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = S_READ_A;
        end
      end
      S_WRITE: begin
        k_d   = '0;
        acc_d = '0;
        if (j_q < LAST) begin
          j_d     = j_q + CW'(1);
          state_d = S_READ_A;
        end else if (i_q < LAST) begin
          j_d     = '0;
          i_d     = i_q + CW'(1);
          state_d = S_READ_A;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode of the memory port and status outputs.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (state_q)
      S_READ_A: begin
        busy            = 1'b1;
        mem_address     = elem_addr(A_BASE, i_q, k_q);
        mem_read_enable = 1'b1;
      end
      S_READ_B: begin
        busy            = 1'b1;
        mem_address     = elem_addr(B_BASE, k_q, j_q);
        mem_read_enable = 1'b1;
      end
      S_WRITE: begin
        busy             = 1'b1;
        mem_address      = elem_addr(C_BASE, i_q, j_q);
        mem_write_data   = acc_q;
        mem_write_enable = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: a behavioural memory, a reference matrix model
// feeding a write scoreboard, and per-scenario tasks.
module tb_matmul_controller;

  localparam int N         = 3;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int A_BASE    = 0;
  localparam int B_BASE    = 9;
  localparam int C_BASE    = 18;
  localparam int MEM_WORDS = 64;
  localparam logic [DATA_W-1:0] SENTINEL = 16'hDEAD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable, mem_read_enable;
  logic [DATA_W-1:0] mem_read_data;

  logic [DATA_W-1:0] mem   [MEM_WORDS];
  logic [DATA_W-1:0] a_m   [N][N];
  logic [DATA_W-1:0] b_m   [N][N];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;

  matmul_controller #(
    .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Combinational read port. Writes are committed by the stimulus process
  // during the write cycle; C never overlaps A or B here, so the exact commit
  // point inside that cycle is not observable.
  assign mem_read_data = (mem_address < ADDR_W'(MEM_WORDS)) ? mem[mem_address[5:0]] : '0;

  // Port exclusivity and quiet outputs whenever no job is running.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(mem_read_enable && mem_write_enable))
        else $error("FAIL port_excl re=%0b we=%0b", mem_read_enable, mem_write_enable);
      if (!busy) begin
        assert (mem_address == '0 && mem_write_data == '0 && !mem_read_enable && !mem_write_enable)
          else $error("FAIL idle_outputs addr=%0h wd=%0h re=%0b we=%0b",
                      mem_address, mem_write_data, mem_read_enable, mem_write_enable);
      end
    end
  end

  task automatic load_mem();
    for (int w = 0; w < MEM_WORDS; w++) mem[w] = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mem[A_BASE + r*N + c] = a_m[r][c];
        mem[B_BASE + r*N + c] = b_m[r][c];
        mem[C_BASE + r*N + c] = SENTINEL;
      end
    end
  endtask

  task automatic push_expected();
    wr_t               e;
    logic [31:0]       p;
    logic [DATA_W-1:0] sum;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
          p   = 32'(a_m[r][k]) * 32'(b_m[k][c]);
          sum = sum + p[15:0];
        end
        e.addr = ADDR_W'(C_BASE + r*N + c);
        e.data = sum;
        sb_q.push_back(e);
      end
    end
  endtask

  // Launches one job and scores each write against the model queue.
  // abort_at > 0 raises reset during that cycle instead of waiting for done.
  task automatic run_job(input bit hold, input int abort_at,
                         output int busy_n, output int done_cyc, output int left);
    wr_t e;
    bit  finished;
    finished = 1'b0;
    busy_n   = 0;
    done_cyc = 0;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy) busy_n++;
      if (mem_write_enable) begin
        compared++;
        if (sb_q.size() == 0) begin
          mismatched++;
          $display("FAIL sb_extra_write cycle=%0d addr=%0d data=%0h expected no write",
                   cyc, mem_address, mem_write_data);
        end else begin
          e = sb_q.pop_front();
          if (mem_address !== e.addr || mem_write_data !== e.data) begin
            mismatched++;
            $display("FAIL sb_write cycle=%0d got addr=%0d data=%0h expected addr=%0d data=%0h",
                     cyc, mem_address, mem_write_data, e.addr, e.data);
          end
        end
        if (mem_address < ADDR_W'(MEM_WORDS)) mem[mem_address[5:0]] = mem_write_data;
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (abort_at != 0 && cyc == abort_at) begin
        reset    = 1'b1;
        finished = 1'b1;
      end
    end
    start = 1'b0;
    if (abort_at == 0) begin
      compared++;
      if (done_cyc == 0) begin
        mismatched++;
        $display("FAIL job_timeout got no done expected done within 200 cycles");
      end
    end
    left = sb_q.size();
    sb_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_address !== '0 || mem_write_data !== '0 ||
        mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL %s got busy=%0b done=%0b addr=%0h wd=%0h we=%0b re=%0b expected all 0",
               name, busy, done, mem_address, mem_write_data, mem_write_enable, mem_read_enable);
    end
  endtask

  task automatic set_rows_123();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = DATA_W'(c + 1);
        b_m[r][c] = DATA_W'(c + 1);
      end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset_state");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_priority_idle");
  endtask

  task automatic test_default();
    int busy_n, done_cyc, left;
    logic [DATA_W-1:0] exp_c [9] = '{16'd6, 16'd12, 16'd18, 16'd6, 16'd12, 16'd18, 16'd6, 16'd12, 16'd18};
    set_rows_123();
    load_mem();
    run_job(1'b0, 0, busy_n, done_cyc, left);
    compared++;
    if (busy_n != 63) begin
      mismatched++;
      $display("FAIL default_busy_cycles got %0d expected 63", busy_n);
    end
    compared++;
    if (done_cyc != 64) begin
      mismatched++;
      $display("FAIL default_done_cycle got %0d expected 64", done_cyc);
    end
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL default_missing_writes got %0d left expected 0", left);
    end
    for (int n = 0; n < 9; n++) begin
      compared++;
      if (mem[C_BASE + n] !== exp_c[n]) begin
        mismatched++;
        $display("FAIL default_c%0d got %0d expected %0d", n, mem[C_BASE + n], exp_c[n]);
      end
    end
    @(negedge clk);
    check_outputs_zero("default_after_done");
  endtask

  task automatic test_identity();
    int busy_n, done_cyc, left;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = DATA_W'(r*N + c + 1);
        b_m[r][c] = (r == c) ? 16'd1 : 16'd0;
      end
    load_mem();
    run_job(1'b0, 0, busy_n, done_cyc, left);
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL identity_missing_writes got %0d left expected 0", left);
    end
    for (int n = 0; n < 9; n++) begin
      compared++;
      if (mem[C_BASE + n] !== DATA_W'(n + 1)) begin
        mismatched++;
        $display("FAIL identity_c%0d got %0d expected %0d", n, mem[C_BASE + n], n + 1);
      end
    end
  endtask

  task automatic test_wrap();
    int busy_n, done_cyc, left;
    logic [DATA_W-1:0] exp_v;
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_m[r][c] = (pass == 0) ? 16'h0100 : 16'hFFFF;
          b_m[r][c] = (pass == 0) ? 16'h0100 : 16'h0001;
        end
      exp_v = (pass == 0) ? 16'h0000 : 16'hFFFD;
      load_mem();
      run_job(1'b0, 0, busy_n, done_cyc, left);
      compared++;
      if (left != 0) begin
        mismatched++;
        $display("FAIL wrap%0d_missing_writes got %0d left expected 0", pass, left);
      end
      for (int n = 0; n < 9; n++) begin
        compared++;
        if (mem[C_BASE + n] !== exp_v) begin
          mismatched++;
          $display("FAIL wrap%0d_c%0d got %0h expected %0h", pass, n, mem[C_BASE + n], exp_v);
        end
      end
    end
  endtask

  task automatic test_start_held();
    int busy_n, done_cyc, left;
    set_rows_123();
    load_mem();
    run_job(1'b1, 0, busy_n, done_cyc, left);
    start = 1'b1;
    compared++;
    if (busy_n != 63 || done_cyc != 64 || left != 0) begin
      mismatched++;
      $display("FAIL held_job got busy=%0d done_cycle=%0d left=%0d expected 63/64/0",
               busy_n, done_cyc, left);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_read_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL held_cycle65 got busy=%0b done=%0b re=%0b expected idle 0/0/0",
               busy, done, mem_read_enable);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || mem_read_enable !== 1'b1 || mem_address !== ADDR_W'(A_BASE)) begin
      mismatched++;
      $display("FAIL held_cycle66 got busy=%0b re=%0b addr=%0d expected 1/1/%0d",
               busy, mem_read_enable, mem_address, A_BASE);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mid_reset();
    int busy_n, done_cyc, left;
    set_rows_123();
    load_mem();
    run_job(1'b0, 20, busy_n, done_cyc, left);
    @(negedge clk);
    check_outputs_zero("midreset_outputs");
    reset = 1'b0;
    compared++;
    if (left != 7) begin
      mismatched++;
      $display("FAIL midreset_writes_left got %0d expected 7", left);
    end
    compared++;
    if (mem[C_BASE] !== 16'd6 || mem[C_BASE + 1] !== 16'd12) begin
      mismatched++;
      $display("FAIL midreset_written got %0d,%0d expected 6,12", mem[C_BASE], mem[C_BASE + 1]);
    end
    for (int n = 2; n < 9; n++) begin
      compared++;
      if (mem[C_BASE + n] !== SENTINEL) begin
        mismatched++;
        $display("FAIL midreset_untouched_c%0d got %0h expected %0h", n, mem[C_BASE + n], SENTINEL);
      end
    end
    load_mem();
    run_job(1'b0, 0, busy_n, done_cyc, left);
    compared++;
    if (busy_n != 63 || done_cyc != 64 || left != 0) begin
      mismatched++;
      $display("FAIL midreset_rerun got busy=%0d done_cycle=%0d left=%0d expected 63/64/0",
               busy_n, done_cyc, left);
    end
    for (int n = 0; n < 9; n++) begin
      compared++;
      if (mem[C_BASE + n] !== DATA_W'(6 * ((n % 3) + 1))) begin
        mismatched++;
        $display("FAIL midreset_rerun_c%0d got %0d expected %0d", n, mem[C_BASE + n], 6 * ((n % 3) + 1));
      end
    end
  endtask

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) mem[w] = '0;
    test_reset();
    test_default();
    test_identity();
    test_wrap();
    test_start_held();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matmul_controller.md
# matmul_controller

Sequencer that drives the data memory unit to compute C = A × B for square N×N matrices stored row-major in data memory. It owns the memory's address, write-data, write-enable and read-enable lines for the duration of a job and uses the memory's combinational read port. It sits between the top-level control (start/done handshake) and `data_memory_unit`. While busy it is the sole master of the memory port.

## Interface
Parameters:
- `N`, 3: matrix dimension; legal range 1..15.
- `DATA_W`, 16: data word width; matches the memory write/read data width.
- `ADDR_W`, 16: memory address width.
- `A_BASE`, 0: word address of A[0][0].
- `B_BASE`, 9: word address of B[0][0].
- `C_BASE`, 18: word address of C[0][0].

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `busy` out 1: high while a job is running (READ_A, READ_B, WRITE).
- `done` out 1: one-cycle pulse after the last C element is written.
- `mem_address` out ADDR_W: memory word address.
- `mem_write_data` out DATA_W: data to write into memory.
- `mem_write_enable` out 1: memory write strobe; memory writes on the rising edge.
- `mem_read_enable` out 1: memory read enable.
- `mem_read_data` in DATA_W: combinational read data for `mem_address`.

## Operation
- FSM states are IDLE, READ_A, READ_B, WRITE and DONE. Memory outputs are decoded from registered state and counters (Moore style).
- Counters:
  - `i` (row) and `j` (column) each run 0..N-1.
  - `k` (inner index) runs 0..N-1.
  - Each counter is ceil(log2 N)+1 bits.
- Registers:
  - `a_reg` (DATA_W) holds the latched A operand.
  - `acc` (DATA_W) holds the running sum.
- IDLE:
  - All mem outputs are 0.
  - On `start`=1: clear i, j, k and acc, then go to READ_A.
- READ_A:
  - Drives `mem_address` = A_BASE + i*N + k and `mem_read_enable`=1.
  - At the edge: `a_reg` <= `mem_read_data`, then go to READ_B.
- READ_B:
  - Drives `mem_address` = B_BASE + k*N + j and `mem_read_enable`=1.
  - At the edge: `acc` <= acc + a_reg*mem_read_data.
  - If k==N-1, go to WRITE. Otherwise k++ and return to READ_A.
- WRITE:
  - Drives `mem_address` = C_BASE + i*N + j, `mem_write_data` = acc and `mem_write_enable`=1.
  - At the edge: k<=0 and acc<=0.
  - If j<N-1: j++, go to READ_A.
  - Else if i<N-1: j<=0, i++, go to READ_A.
  - Else go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE unconditionally.
- Arithmetic:
  - The product is full 2·DATA_W width, truncated to DATA_W.
  - The accumulate is modulo 2^DATA_W. No saturation and no overflow flag.
  - Address arithmetic is computed at ADDR_W and wraps modulo 2^ADDR_W.
- `mem_read_enable` and `mem_write_enable` are never high in the same cycle.
- `start` is ignored in READ_A, READ_B, WRITE and DONE. It is not queued.
- Reset at any time:
  - Next state is IDLE, with i, j, k, a_reg and acc all cleared.
  - C elements already written stay in memory; no rollback.
- Reset has priority over `start` in the same cycle.
- Inputs A and B are not protected. If C overlaps A or B, later reads see the updated values. This is permitted and undefined for the result.

## Timing
- Reset values:
  - `busy`=0, `done`=0.
  - `mem_address`=0, `mem_write_data`=0.
  - `mem_write_enable`=0, `mem_read_enable`=0.
- Cycle numbering: `start` is sampled at edge 0, and cycle 1 is the first READ_A.
- Each C element takes 2N+1 cycles. The job takes N²(2N+1) busy cycles; for N=3 that is 63.
- Write of C[i][j] occurs in cycle (i*N+j+1)(2N+1). For N=3: C[0][0] in cycle 7, C[2][2] in cycle 63.
- `done` is high in cycle N²(2N+1)+1 (cycle 64 for N=3). `busy` is low in that cycle.
- Earliest next `start` acceptance is the edge ending the first IDLE cycle after DONE.
- Zero-wait memory: read data is used in the same cycle the address is driven.

## Test plan
- **Default data:** memory holds A=B=[[1,2,3]×3] at addresses 0..17; pulse `start`.
  - C at 18..26 = 6,12,18,6,12,18,6,12,18.
  - `busy` is high for exactly 63 cycles; `done` pulses in cycle 64.
- **Identity:** B=identity, A=1..9; run.
  - C = 1..9.
  - Each `mem_write_enable` cycle's `mem_address` = 18+n, in order n=0..8.
- **Wrap-around:** all A and B elements = 16'h0100.
  - All C = 0 (truncated product).
  - With A=16'hFFFF, B=1: every C = 16'hFFFD.
- **Start while busy:** hold `start` high for the whole job.
  - Exactly one job runs and `done` pulses once at cycle 64.
  - A second job begins only after one IDLE cycle, with READ_A at cycle 66.
- **Mid-job reset:** assert `reset` at cycle 20.
  - Next cycle all outputs are 0 and the state is IDLE.
  - C[0][0..1] are written; C[0][2] onward are untouched.
  - A subsequent `start` produces a correct full result.
- **Port exclusivity:** assertion monitor over all tests.
  - Read and write enables are never simultaneously high.
  - Enables and addresses are 0 in IDLE and DONE.
